// File: rtl/network_mac_pkg.sv
// rtl/network_mac_pkg.sv - shared FSM state, accumulator default width and saturation limits for the MAC accumulator
package network_mac_pkg;

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } state_t;

   localparam int ACC_WIDTH_DEF = 36;

   localparam int OUT_MAX = 32767;
   localparam int OUT_MIN = -32768;

endpackage

// File: rtl/network_mac_requant.sv
// rtl/network_mac_requant.sv - combinational shift, 16-bit saturation and optional ReLU (NETWORK_MAC_RELU_EN)
module network_mac_requant
   import network_mac_pkg::*;
#(
   parameter int ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int SHIFT     = 13
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   output logic        [15:0]          result
);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(OUT_MAX);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(OUT_MIN);

   logic signed [ACC_WIDTH-1:0] shifted;
   logic        [15:0]          sat;

   // Drop fractional bits (rounding offset is already in acc), clamp to 16-bit signed range
   always_comb begin
      shifted = acc >>> SHIFT;
      if (shifted > SAT_MAX) begin
         sat = 16'(OUT_MAX);
      end else if (shifted < SAT_MIN) begin
         sat = 16'(OUT_MIN);
      end else begin
         sat = shifted[15:0];
      end
`ifdef NETWORK_MAC_RELU_EN
      result = sat[15] ? 16'd0 : sat;
`else
      result = sat;
`endif
   end

endmodule

// File: rtl/network_mac_acc_30s_16s.sv
// rtl/network_mac_acc_30s_16s.sv - accumulates TAPS 30-bit products plus bias, emits requantized 16-bit result (NETWORK_MAC_RELU_EN optional)
module network_mac_acc_30s_16s
   import network_mac_pkg::*;
#(
   parameter int TAPS      = 9,
   parameter int SHIFT     = 13,
   parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic [29:0] prod_dout,
   input  logic        prod_valid,
   output logic        prod_ready,
   input  logic [15:0] bias,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
   localparam logic signed [ACC_WIDTH-1:0] ROUND_OFS =
      {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);

   state_t                      state;
   state_t                      state_next;
   logic        [CNT_W-1:0]     tap_cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] bias_ext;
   logic        [15:0]          requant;
   logic                        accept;
   logic                        last_tap;

   assign prod_ext = {{(ACC_WIDTH-30){prod_dout[29]}}, prod_dout};
   assign bias_ext = {{(ACC_WIDTH-16){bias[15]}}, bias};
   assign accept   = prod_valid && prod_ready;
   assign last_tap = (tap_cnt == LAST_TAP);

   // First product of a group seeds acc with scaled bias plus half-LSB rounding offset
   always_comb begin
      acc_base = acc;
      if (tap_cnt == '0) begin
         acc_base = (bias_ext <<< SHIFT) + ROUND_OFS;
      end
      acc_next = acc_base + prod_ext;
   end

   // Requantize the sum that includes the product being accepted, so the result registers on the last tap
   network_mac_requant #(
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT     (SHIFT)
   ) u_requant (
      .acc    (acc_next),
      .result (requant)
   );

   // FSM state register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state: leave ACCUM on the last tap, return once the result is taken
   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (accept && last_tap) state_next = OUTPUT;
         OUTPUT:  if (out_ready)          state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // FSM outputs: products flow only while accumulating, result valid only while holding
   always_comb begin
      prod_ready = (state == ACCUM);
      out_valid  = (state == OUTPUT);
   end

   // Accumulator, tap counter and result register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc      <= '0;
         tap_cnt  <= '0;
         out_data <= '0;
      end else if (accept) begin
         acc     <= acc_next;
         tap_cnt <= last_tap ? '0 : tap_cnt + CNT_W'(1);
         if (last_tap) begin
            out_data <= requant;
         end
      end
   end

endmodule

// File: tb/tb_network_mac_acc_30s_16s.sv
// tb/tb_network_mac_acc_30s_16s.sv - directed-vector bench for network_mac_acc_30s_16s (TAPS=9, SHIFT=13)
module tb_network_mac_acc_30s_16s;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [29:0] prod_dout;
   logic        prod_valid;
   logic        prod_ready;
   logic [15:0] bias;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int n_vec  = 0;
   int n_fail = 0;

   network_mac_acc_30s_16s dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .prod_dout  (prod_dout),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .bias       (bias),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one product and wait until it is taken at a rising edge; returns just after that edge
   task automatic send_prod(input int p, input int b);
      int n;
      n = 0;
      prod_dout  = 30'(p);
      bias       = 16'(b);
      prod_valid = 1'b1;
      while (!prod_ready && n < 50) begin
         @(negedge ap_clk);
         n++;
      end
      if (!prod_ready) begin
         check("prod_ready_timeout", 0, 1);
      end
      @(posedge ap_clk);
      #1;
      prod_valid = 1'b0;
      prod_dout  = 30'($urandom);
      bias       = 16'($urandom);
   endtask

   // Nine products (base everywhere, sp_val at sp_idx), bias on the first only; check result and handshake
   task automatic run_group(input string tag, input int base, input int sp_idx, input int sp_val,
                            input int b, input int exp, input logic consume);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) check({tag, "_valid_early"}, int'(out_valid), 0);
         send_prod((i == sp_idx) ? sp_val : base, (i == 0) ? b : int'($urandom));
      end
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_data"}, int'($signed(out_data)), exp);
      if (consume) begin
         out_ready = 1'b1;
         @(posedge ap_clk);
         #1;
         out_ready = 1'b0;
         check({tag, "_valid_drop"}, int'(out_valid), 0);
         check({tag, "_ready_back"}, int'(prod_ready), 1);
      end
   endtask

   initial begin
      int held;
      int exp_neg;
      int exp_min;
      ap_rst     = 1'b1;
      prod_dout  = '0;
      prod_valid = 1'b0;
      bias       = '0;
      out_ready  = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;

      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_prod_ready", int'(prod_ready), 1);

`ifdef NETWORK_MAC_RELU_EN
      exp_neg = 0;
      exp_min = 0;
`else
      exp_neg = -9;
      exp_min = -32768;
`endif

      run_group("basic", 8192, -1, 0, 3, 12, 1'b1);
      run_group("round_up", 0, 4, 4096, 0, 1, 1'b1);
      run_group("round_neg", 0, 4, -4096, 0, 0, 1'b1);
      run_group("sat_pos", 536870911, -1, 0, 0, 32767, 1'b1);
      run_group("sat_neg", -536870912, -1, 0, 0, exp_min, 1'b1);
      run_group("neg", -8192, -1, 0, 0, exp_neg, 1'b1);

      // Backpressure: next group's first product waits while the result is held
      run_group("hold", 8192, 2, 16384, 1, 11, 1'b0);
      held       = int'(out_data);
      prod_dout  = 30'd8192;
      bias       = 16'd0;
      prod_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge ap_clk);
         check("hold_prod_ready", int'(prod_ready), 0);
         check("hold_out_data", int'(out_data), held);
      end
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      out_ready = 1'b0;
      run_group("after_hold", 8192, -1, 0, 0, 9, 1'b1);

      // Reset mid-group discards the partial sum
      for (int i = 0; i < 4; i++) send_prod(8192, 5);
      @(negedge ap_clk);
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_prod_ready", int'(prod_ready), 1);
      run_group("after_midrst", 8192, -1, 0, 0, 9, 1'b1);

      // Reset while holding a result drops it
      run_group("pre_outrst", 8192, -1, 0, 3, 12, 1'b0);
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      check("outrst_out_valid", int'(out_valid), 0);
      check("outrst_out_data", int'(out_data), 0);
      run_group("after_outrst", 8192, -1, 0, 0, 9, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/network_mac_acc_30s_16s.md
NETWORK_MAC_ACC_30S_16S -- requirements
Module: network_mac_acc_30s_16s

Interface
REQ-001 SHALL have parameter TAPS, default 9, products summed per output (legal 1..32).
REQ-002 SHALL have parameter SHIFT, default 13, fractional bits removed on requantize (legal 1..20).
REQ-003 SHALL have parameter ACC_WIDTH, default 36, signed accumulator width.
REQ-004 SHALL have port ap_clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port ap_rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port prod_dout, input, 30, signed product from the 16s x 14s multiplier.
REQ-007 SHALL have port prod_valid, input, 1, prod_dout valid.
REQ-008 SHALL have port prod_ready, output, 1, block accepts product this cycle.
REQ-009 SHALL have port bias, input, 16, signed bias in output Q format.
REQ-010 SHALL have port out_data, output, 16, signed requantized result.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts out_data.

Function
REQ-013 SHALL implement FSM states ACCUM and OUTPUT.
REQ-014 SHALL drive prod_ready high only in ACCUM.
REQ-015 SHALL accept a product only on prod_valid and prod_ready both high.
REQ-016 SHALL, on the first accepted product of a group (tap_cnt==0), load acc = (bias sign-extended <<< SHIFT) + 2^(SHIFT-1) + sign-extended prod_dout, sampling bias that cycle only.
REQ-017 SHALL, on later accepted products, set acc = acc + sign-extended prod_dout.
REQ-018 SHALL increment tap_cnt per accepted product, wrapping to 0 after TAPS-1.
REQ-019 SHALL, when the product with tap_cnt==TAPS-1 is accepted, transition to OUTPUT and register the requantized result so out_valid rises the next cycle (latency 1 cycle from last product).
REQ-020 SHALL requantize as arithmetic shift right by SHIFT of the final acc, then saturate to [-32768, 32767] (round half toward +inf via REQ-016 offset).
REQ-021 SHALL hold out_valid high and out_data stable in OUTPUT until out_ready is high.
REQ-022 SHALL, on out_valid and out_ready both high, return to ACCUM and deassert out_valid the next cycle; prod_ready is high that next cycle.
REQ-023 SHALL, with TAPS=1, produce one output per accepted product.
REQ-024 SHALL ignore prod_dout and bias whenever no product is accepted.

Reset
REQ-025 SHALL, when ap_rst is high at a clock edge, set state=ACCUM, tap_cnt=0, acc=0, out_valid=0, out_data=0; prod_ready is high in the first cycle after reset.
REQ-026 SHALL, on reset mid-group or in OUTPUT, discard the partial sum and pending output; the next accepted product starts a new group.

Configuration
REQ-027 SHALL, when macro NETWORK_MAC_RELU_EN is defined, clamp any negative saturated result to 0 before registering out_data.
REQ-028 SHALL, without NETWORK_MAC_RELU_EN, output the signed saturated result unmodified.

Structure
REQ-029 SHALL take the FSM state enum, ACC_WIDTH default, and OUT_MAX/OUT_MIN saturation constants from shared package network_mac_pkg.
REQ-030 SHALL place shift, saturate, and optional ReLU in combinational sub-module network_mac_requant.

Verification (TAPS=9, SHIFT=13 unless stated)
REQ-031 SHALL cover 9 products of 8192, bias 3 -> single output 12, out_valid one cycle after 9th product.
REQ-032 SHALL cover 9 products of 0 except one 4096 -> output 1; one -4096 -> output 0 (rounding).
REQ-033 SHALL cover 9 products of 536870911 -> output 32767; 9 of -536870912 -> output -32768.
REQ-034 SHALL cover 9 products of -8192 -> output -9 without NETWORK_MAC_RELU_EN, 0 with it.
REQ-035 SHALL cover out_ready held low 5 cycles -> prod_ready low, out_data constant, no product lost; stream continuing afterwards yields correct next result.
REQ-036 SHALL cover ap_rst pulsed after 4 accepted products -> out_valid 0; next 9 products of 8192, bias 0 -> output 9.
